// File: rtl/updown_modn_counter.sv
// rtl/updown_modn_counter.sv - modulo-N up/down counter with load, wrap and one-shot halt
//
// Purpose: counts 0..MODULUS-1 up or down. In wrap mode the terminal value
// rolls over with a one-cycle wrap pulse; in one-shot mode the counter halts
// at the terminal value and raises done until load or clr.
//
// Ports:
//   clk      in   1      rising-edge clock
//   clr      in   1      asynchronous active-high reset
//   en       in   1      count enable
//   up_dn    in   1      direction, 1 = up, 0 = down
//   load     in   1      synchronous parallel load strobe (beats en)
//   d        in   WIDTH  parallel load value
//   one_shot in   1      0 = wrap at terminal, 1 = halt at terminal
//   q        out  WIDTH  registered count
//   tc       out  1      combinational terminal-count flag
//   wrap     out  1      registered one-cycle wrap pulse
//   done     out  1      registered halt flag (one-shot mode)
//   load_err out  1      registered one-cycle out-of-range-load pulse

module updown_modn_counter #(
   parameter int                WIDTH   = 3,
   parameter longint unsigned   MODULUS = 8
) (
   input  logic             clk,
   input  logic             clr,
   input  logic             en,
   input  logic             up_dn,
   input  logic             load,
   input  logic [WIDTH-1:0] d,
   input  logic             one_shot,
   output logic [WIDTH-1:0] q,
   output logic             tc,
   output logic             wrap,
   output logic             done,
   output logic             load_err
);

   // 64-bit comparison so MODULUS = 2^32 is representable when WIDTH = 32.
   generate
      if (WIDTH < 1 || WIDTH > 32 || MODULUS < 2 || MODULUS > (64'd1 << WIDTH)) begin : g_bad_params
         $error("updown_modn_counter: illegal WIDTH/MODULUS combination");
      end
   endgenerate

   localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MODULUS - 1);

   logic [WIDTH-1:0] count_q, count_d;
   logic             wrap_q, wrap_d;
   logic             done_q, done_d;
   logic             load_err_q, load_err_d;

   logic             at_term;
   logic             d_in_range;

   // Terminal value depends on the direction currently presented.
   assign at_term    = up_dn ? (count_q == MAX_VAL) : (count_q == '0);
   assign d_in_range = (d <= MAX_VAL);

   always_comb begin
      count_d    = count_q;
      wrap_d     = 1'b0;
      done_d     = done_q;
      load_err_d = 1'b0;

      if (load) begin
         // Out-of-range loads saturate to the top of the count range.
         count_d    = d_in_range ? d : MAX_VAL;
         load_err_d = ~d_in_range;
         done_d     = 1'b0;
      end else if (en && !done_q) begin
         if (at_term) begin
            if (one_shot) begin
               done_d = 1'b1;
            end else begin
               count_d = up_dn ? '0 : MAX_VAL;
               wrap_d  = 1'b1;
            end
         end else begin
            // Never at terminal here, so +/-1 cannot leave 0..MODULUS-1.
            count_d = up_dn ? (count_q + 1'b1) : (count_q - 1'b1);
         end
      end
   end

   always_ff @(posedge clk or posedge clr) begin
      if (clr) begin
         count_q    <= '0;
         wrap_q     <= 1'b0;
         done_q     <= 1'b0;
         load_err_q <= 1'b0;
      end else begin
         count_q    <= count_d;
         wrap_q     <= wrap_d;
         done_q     <= done_d;
         load_err_q <= load_err_d;
      end
   end

   assign q        = count_q;
   assign tc       = en & ~load & at_term;
   assign wrap     = wrap_q;
   assign done     = done_q;
   assign load_err = load_err_q;

endmodule

// File: tb/tb_updown_modn_counter.sv
// tb/tb_updown_modn_counter.sv - scoreboard bench for updown_modn_counter

module tb_updown_modn_counter;

   localparam int M = 6;

   logic       clk = 1'b0;
   logic       clr = 1'b0;
   logic       en = 1'b0, up_dn = 1'b1, load = 1'b0, one_shot = 1'b0;
   logic [2:0] d = 3'd0;
   logic [2:0] q;
   logic       tc, wrap, done, load_err;

   logic       en8 = 1'b0, up8 = 1'b1, load8 = 1'b0, os8 = 1'b0;
   logic [2:0] d8 = 3'd0;
   logic [2:0] q8;
   logic       tc8, wrap8, done8, lerr8;

   updown_modn_counter #(.WIDTH(3), .MODULUS(6)) dut (
      .clk(clk), .clr(clr), .en(en), .up_dn(up_dn), .load(load), .d(d),
      .one_shot(one_shot), .q(q), .tc(tc), .wrap(wrap), .done(done),
      .load_err(load_err)
   );

   updown_modn_counter #(.WIDTH(3), .MODULUS(8)) dut8 (
      .clk(clk), .clr(clr), .en(en8), .up_dn(up8), .load(load8), .d(d8),
      .one_shot(os8), .q(q8), .tc(tc8), .wrap(wrap8), .done(done8),
      .load_err(lerr8)
   );

   always #5 clk = ~clk;

   typedef struct {
      int q;
      bit wrap;
      bit done;
      bit lerr;
   } exp_t;

   exp_t exp_q[$];

   int n_checks = 0;
   int n_pass   = 0;

   // Reference state for the MODULUS=6 instance.
   int m_q    = 0;
   bit m_done = 1'b0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
      n_checks++;
      if (got === want) n_pass++;
      else $display("FAIL %s: got %0d expected %0d", tag, got, want);
   endtask

   // One clocked step: drive at negedge, check tc, push the prediction,
   // then pop and compare just after the rising edge.
   task automatic step(input bit e, input bit u, input bit l, input int dv, input bit os);
      exp_t x;
      bit   term;
      @(negedge clk);
      en = e; up_dn = u; load = l; d = 3'(dv); one_shot = os;
      #1;
      term = u ? (m_q == M - 1) : (m_q == 0);
      check("tc", tc, e && !l && term);

      x.wrap = 1'b0;
      x.lerr = 1'b0;
      if (l) begin
         if (dv < M) m_q = dv;
         else begin
            m_q    = M - 1;
            x.lerr = 1'b1;
         end
         m_done = 1'b0;
      end else if (e && !m_done) begin
         if (term && os) m_done = 1'b1;
         else if (term) begin
            m_q    = u ? 0 : M - 1;
            x.wrap = 1'b1;
         end else m_q = u ? m_q + 1 : m_q - 1;
      end
      x.q    = m_q;
      x.done = m_done;
      exp_q.push_back(x);

      @(posedge clk);
      #1;
      if (exp_q.size() == 0) check("sb_empty", 1, 0);
      else begin
         x = exp_q.pop_front();
         check("q", q, x.q);
         check("wrap", wrap, x.wrap);
         check("done", done, x.done);
         check("load_err", load_err, x.lerr);
      end
   endtask

   // Asynchronous clear between edges; outputs must drop without a clock.
   task automatic pulse_clr();
      @(negedge clk);
      en = 1'b0; load = 1'b0;
      #2 clr = 1'b1;
      #1;
      check("clr_q", q, 0);
      check("clr_wrap", wrap, 0);
      check("clr_done", done, 0);
      check("clr_lerr", load_err, 0);
      m_q    = 0;
      m_done = 1'b0;
      #1 clr = 1'b0;
   endtask

   int seq33[8] = '{1, 2, 3, 4, 5, 0, 1, 2};
   int seq34[8] = '{5, 4, 3, 2, 1, 0, 5, 4};
   int seq35[4] = '{4, 5, 5, 5};
   int wraps;

   initial begin
      // Clear for 5 ns straddling a rising edge while en is asserted.
      #12;
      en  = 1'b1;
      clr = 1'b1;
      #1;
      check("rst_q", q, 0);
      check("rst_wrap", wrap, 0);
      check("rst_done", done, 0);
      check("rst_lerr", load_err, 0);
      #3;
      check("rst_hold_q", q, 0);
      #1 clr = 1'b0;
      en = 1'b0;

      for (int i = 0; i < 8; i++) begin
         step(1, 1, 0, 0, 0);
         check("seq_up", q, seq33[i]);
      end

      step(0, 1, 1, 0, 0);
      for (int i = 0; i < 8; i++) begin
         step(1, 0, 0, 0, 0);
         check("seq_dn", q, seq34[i]);
      end

      step(0, 1, 1, 3, 0);
      for (int i = 0; i < 4; i++) begin
         step(1, 1, 0, 0, 1);
         check("seq_os", q, seq35[i]);
      end
      check("os_done", done, 1);
      step(1, 0, 0, 0, 1);   // direction flip while halted: still held
      step(1, 1, 0, 0, 0);   // one_shot dropped: done stays
      check("os_hold_q", q, 5);
      step(1, 1, 1, 2, 1);
      check("os_reload", q, 2);
      check("os_done_clr", done, 0);

      step(0, 1, 1, 7, 0);
      check("lerr_sat", q, 5);
      step(0, 1, 0, 0, 0);
      step(0, 1, 1, 6, 0);   // d == MODULUS is out of range
      step(0, 1, 1, 5, 0);   // d == MODULUS-1 is legal
      step(1, 1, 1, 4, 0);
      check("load_beats_en", q, 4);

      pulse_clr();
      step(0, 1, 1, 5, 0);
      step(1, 1, 0, 0, 0);   // 5 -> 0 with wrap pulse
      pulse_clr();           // truncates the wrap pulse
      step(0, 1, 1, 7, 0);
      pulse_clr();           // truncates the load_err pulse

      for (int i = 0; i < 60; i++)
         step(1'($urandom), 1'($urandom), ($urandom_range(0, 7) == 0),
              $urandom_range(0, 7), ($urandom_range(0, 3) == 0));

      wraps = 0;
      for (int i = 0; i < 9; i++) begin
         @(negedge clk);
         en8 = 1'b1;
         @(posedge clk);
         #1;
         check("mod8_q", q8, (i + 1) % 8);
         if (wrap8) wraps++;
      end
      en8 = 1'b0;
      check("mod8_wraps", wraps, 1);
      check("sb_drained", exp_q.size(), 0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/updown_modn_counter.md
UPDOWN_MODN_COUNTER -- requirements
Module: updown_modn_counter

Interface
REQ-001 Parameter WIDTH, default 3, counter width in bits; legal range 1..32.
REQ-002 Parameter MODULUS, default 8, count range 0..MODULUS-1; legal range 2..2^WIDTH; illegal values SHALL be rejected at elaboration.
REQ-003 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-004 clr  input  1  reset, asynchronous, active-high.
REQ-005 en  input  1  count enable.
REQ-006 up_dn  input  1  direction: 1 = up, 0 = down.
REQ-007 load  input  1  synchronous parallel load strobe.
REQ-008 d  input  WIDTH  parallel load value.
REQ-009 one_shot  input  1  mode: 0 = wrap at terminal value, 1 = halt at terminal value.
REQ-010 q  output  WIDTH  registered count.
REQ-011 tc  output  1  combinational terminal-count flag.
REQ-012 wrap  output  1  registered one-cycle wrap pulse.
REQ-013 done  output  1  registered halt flag, one-shot mode.
REQ-014 load_err  output  1  registered one-cycle out-of-range-load pulse.

Function
REQ-015 Priority per edge SHALL be clr > load > en; en=0 and load=0 SHALL hold q.
REQ-016 load=1: q SHALL take d on the next edge when d < MODULUS; otherwise q SHALL take MODULUS-1 and load_err SHALL pulse high for that one cycle.
REQ-017 load SHALL clear done and SHALL NOT assert wrap, regardless of en.
REQ-018 Terminal value SHALL be MODULUS-1 when up_dn=1 and 0 when up_dn=0.
REQ-019 tc SHALL equal en & ~load & (q == terminal value for current up_dn).
REQ-020 en=1, up_dn=1, q < MODULUS-1: q SHALL increment by 1.
REQ-021 en=1, up_dn=0, q > 0: q SHALL decrement by 1.
REQ-022 en=1 at terminal value with one_shot=0: q SHALL wrap (MODULUS-1 -> 0 up, 0 -> MODULUS-1 down) and wrap SHALL be high for exactly the following cycle.
REQ-023 en=1 at terminal value with one_shot=1: q SHALL hold, done SHALL set on that edge and stay high; wrap SHALL stay low.
REQ-024 While done=1, en SHALL be ignored; only load or clr SHALL clear done.
REQ-025 done=1 and up_dn changed so q is no longer terminal: q SHALL still hold until load or clr.
REQ-026 Changing up_dn mid-count SHALL take effect on the next enabled edge with no skipped or repeated value.
REQ-027 one_shot changed 0->1 with done=0 SHALL take effect at the next terminal event; 1->0 with done=1 SHALL NOT clear done.
REQ-028 Latency: q, wrap, done, load_err SHALL reflect an edge's inputs immediately after that edge; tc SHALL have zero latency.
REQ-029 Arithmetic SHALL be WIDTH bits; q SHALL never leave 0..MODULUS-1, including when MODULUS = 2^WIDTH.

Reset
REQ-030 clr=1 SHALL immediately, without clk, force q=0, wrap=0, done=0, load_err=0.
REQ-031 While clr=1, all inputs SHALL be ignored; the first edge after clr falls SHALL be a normal operating edge.
REQ-032 clr asserted mid-count or mid-pulse SHALL truncate any wrap/load_err pulse.

Verification (WIDTH=3, MODULUS=6 unless noted)
REQ-033 clr pulse 5 ns with clk running, then en=1 up_dn=1 one_shot=0 for 8 edges -> q = 1,2,3,4,5,0,1,2; tc high while q=5; wrap high for the one cycle after q 5->0.
REQ-034 en=1 up_dn=0 from q=0 -> q=5,4,...; tc high at q=0; wrap pulse after 0->5.
REQ-035 one_shot=1 up from q=3 -> q=4,5,5,5; done set after the edge at q=5; no wrap; then load=1 d=2 -> q=2, done=0.
REQ-036 load=1 d=7 -> q=5, load_err high one cycle; load=1 together with en=1 d=4 -> q=4, no increment.
REQ-037 clr asserted between edges at q=4 -> q=0 before next edge; wrap/done/load_err 0.
REQ-038 WIDTH=3, MODULUS=8, up for 9 edges from 0 -> q 1..7,0,1; wrap once.
